g3_chain_walker: RTL and testbench
==================================

G3_CHAIN_WALKER -- requirements
Module: g3_chain_walker

Interface
REQ-001 SHALL have parameter INDEX_BIT_LEN, default 11, table index and rule ID width.
REQ-002 SHALL have parameter PACKET_BIT_LEN, default 104, 5-tuple width.
REQ-003 SHALL have parameter NULL_INDEX, default all-ones of INDEX_BIT_LEN, end-of-chain marker.
REQ-004 SHALL have parameter MAX_HOPS, default 16, range 1..255, maximum entries examined per packet.
REQ-005 SHALL have ports `clk` (input, 1, sole clock) and `rst` (input, 1, synchronous active-high reset).
REQ-006 SHALL have ports `in_valid` (input, 1, request present) and `in_ready` (output, 1, walker can accept).
REQ-007 SHALL have ports `in_tuple` (input, PACKET_BIT_LEN, packet 5-tuple) and `in_head` (input, INDEX_BIT_LEN, chain head index).
REQ-008 SHALL have ports `tbl_search_index` (output, INDEX_BIT_LEN) and `tbl_tuple` (output, PACKET_BIT_LEN), both driven to the G3 table stage.
REQ-009 SHALL have ports `tbl_match` (input, 1), `tbl_ruleID` (input, INDEX_BIT_LEN) and `tbl_next_index` (input, INDEX_BIT_LEN), all registered results from the G3 table stage.
REQ-010 SHALL have ports `out_valid` (output, 1), `out_ready` (input, 1), `out_match` (output, 1) and `out_ruleID` (output, INDEX_BIT_LEN).
REQ-011 SHALL have ports `out_hops` (output, 8, entries examined) and `out_overflow` (output, 1, MAX_HOPS exhausted).
REQ-012 SHALL have ports `stat_pkts`, `stat_matches` and `stat_overflows` (outputs, 32 each).

Function
REQ-013 SHALL implement the states IDLE, LOOKUP, RESULT and DONE.
REQ-014 SHALL assert `in_ready` only in IDLE, and SHALL treat `in_valid` and `in_ready` both high at a rising edge as an accept.
REQ-015 On accept, SHALL latch `in_tuple` and `in_head` into the current index, clear the hop count and go to LOOKUP.
REQ-016 SHALL drive `tbl_search_index` = current index and `tbl_tuple` = latched tuple in every state.
REQ-017 In LOOKUP, SHALL increment the hop count and go to RESULT.
REQ-018 SHALL treat `tbl_match`, `tbl_ruleID` and `tbl_next_index` as valid only in RESULT, i.e. 1 cycle after the index is presented, and SHALL ignore them in all other states.
REQ-019 RESULT priority 1: if `tbl_match`=1, SHALL capture `out_match`=1 and `out_ruleID`=`tbl_ruleID` and go to DONE (first match in chain wins).
REQ-020 RESULT priority 2: else if `tbl_next_index`==NULL_INDEX, SHALL set `out_match`=0 and `out_ruleID`=0 and go to DONE.
REQ-021 RESULT priority 3: else if hop count==MAX_HOPS, SHALL set `out_match`=0 and `out_overflow`=1 and go to DONE.
REQ-022 RESULT otherwise: SHALL set current index=`tbl_next_index` and go to LOOKUP.
REQ-023 SHALL take 2 cycles per hop; accept-to-`out_valid` latency SHALL be 2*hops+1 cycles.
REQ-024 In DONE, SHALL hold `out_valid`=1 with stable outputs until `out_ready`=1, then go to IDLE; the next accept is possible only the cycle after.
REQ-025 SHALL take no special action when `in_head`==NULL_INDEX; the head entry is still looked up once.
REQ-026 SHALL keep `out_hops` equal to the hop count, saturating at 255.
REQ-027 SHALL clear `out_overflow` on each accept.

Reset
REQ-028 When `rst`=1 at a rising edge, SHALL go to IDLE from any state, abandoning any walk in progress.
REQ-029 SHALL reset `out_valid`, `out_match`, `out_overflow`, `out_ruleID`, `out_hops`, the current index, the tuple register and all statistics counters to 0.
REQ-030 SHALL drive `in_ready`=1 in the first cycle after reset deasserts.

Configuration
REQ-031 With G3_WALK_STATS_EN defined, SHALL increment `stat_pkts` on each DONE-to-IDLE handshake, `stat_matches` when that result has `out_match`=1, and `stat_overflows` when it has `out_overflow`=1; all three SHALL wrap modulo 2^32.
REQ-032 Without G3_WALK_STATS_EN, SHALL tie the three `stat_*` ports to 0, include no counter logic, and keep the port list unchanged.

Verification
REQ-033 Head=5, entry 5 matches with ruleID=0x2A, `out_ready`=1 -> `out_valid` 3 cycles after accept, `out_match`=1, `out_ruleID`=0x2A, `out_hops`=1.
REQ-034 Chain 3->7->9, only 9 matches with ruleID=0x101 -> `out_match`=1, `out_ruleID`=0x101, `out_hops`=3, `out_valid` 7 cycles after accept.
REQ-035 Chain 3->7->NULL, no match -> `out_match`=0, `out_ruleID`=0, `out_overflow`=0, `out_hops`=2.
REQ-036 MAX_HOPS=4, cyclic chain 1->2->1 with no match -> `out_overflow`=1, `out_hops`=4, `out_match`=0.
REQ-037 `out_ready`=0 for 5 cycles in DONE -> outputs stable, `in_ready`=0 throughout; release -> IDLE, then a new accept.
REQ-038 `rst` pulsed in RESULT of hop 2 -> next cycle `in_ready`=1, `out_valid`=0; with G3_WALK_STATS_EN defined, `stat_pkts`=0.

Source files
------------

// File: rtl/g3_chain_walker_if.sv
// g3_chain_walker_if: bundles the request, table-stage, result and statistics
// signals of the G3 chain walker.
//   slave  : walker side (consumes requests and table results, produces results)
//   master : environment side (issues requests, models the table, takes results)
interface g3_chain_walker_if #(
    parameter int unsigned INDEX_BIT_LEN  = 11,
    parameter int unsigned PACKET_BIT_LEN = 104
);
    // request handshake
    logic                      in_valid;
    logic                      in_ready;
    logic [PACKET_BIT_LEN-1:0] in_tuple;
    logic [INDEX_BIT_LEN-1:0]  in_head;

    // table stage
    logic [INDEX_BIT_LEN-1:0]  tbl_search_index;
    logic [PACKET_BIT_LEN-1:0] tbl_tuple;
    logic                      tbl_match;
    logic [INDEX_BIT_LEN-1:0]  tbl_ruleID;
    logic [INDEX_BIT_LEN-1:0]  tbl_next_index;

    // result handshake
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_match;
    logic [INDEX_BIT_LEN-1:0]  out_ruleID;
    logic [7:0]                out_hops;
    logic                      out_overflow;

    // statistics
    logic [31:0]               stat_pkts;
    logic [31:0]               stat_matches;
    logic [31:0]               stat_overflows;

    modport slave (
        input  in_valid, in_tuple, in_head,
        input  tbl_match, tbl_ruleID, tbl_next_index,
        input  out_ready,
        output in_ready,
        output tbl_search_index, tbl_tuple,
        output out_valid, out_match, out_ruleID, out_hops, out_overflow,
        output stat_pkts, stat_matches, stat_overflows
    );

    modport master (
        output in_valid, in_tuple, in_head,
        output tbl_match, tbl_ruleID, tbl_next_index,
        output out_ready,
        input  in_ready,
        input  tbl_search_index, tbl_tuple,
        input  out_valid, out_match, out_ruleID, out_hops, out_overflow,
        input  stat_pkts, stat_matches, stat_overflows
    );
endinterface

// File: rtl/g3_chain_walker.sv
// g3_chain_walker: walks a hash-chain of G3 table entries for one packet at a
// time. Each hop presents an index to the registered table stage (LOOKUP) and
// evaluates its registered answer one cycle later (RESULT). The walk ends on the
// first matching entry, at the end-of-chain marker, or after MAX_HOPS entries.
//
// Ports:
//   clk  - sole clock
//   rst  - synchronous active-high reset
//   bus  - g3_chain_walker_if.slave:
//          in_valid/in_ready/in_tuple/in_head      request handshake
//          tbl_search_index/tbl_tuple               index/tuple to table stage
//          tbl_match/tbl_ruleID/tbl_next_index      registered table answer
//          out_valid/out_ready/out_match/out_ruleID/out_hops/out_overflow
//                                                   result handshake
//          stat_pkts/stat_matches/stat_overflows    32-bit wrapping counters
//
// Build option: define G3_WALK_STATS_EN to enable the statistics counters;
// otherwise the stat_* outputs are tied to zero.
module g3_chain_walker #(
    parameter int unsigned             INDEX_BIT_LEN  = 11,
    parameter int unsigned             PACKET_BIT_LEN = 104,
    parameter logic [INDEX_BIT_LEN-1:0] NULL_INDEX    = '1,
    parameter int unsigned             MAX_HOPS       = 16
) (
    input  logic             clk,
    input  logic             rst,
    g3_chain_walker_if.slave bus
);

    localparam int unsigned HOP_W   = 8;
    localparam logic [HOP_W-1:0] HOP_LIMIT = HOP_W'(MAX_HOPS);
    localparam logic [HOP_W-1:0] HOP_SAT   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESULT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                    state_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic                      out_match_q;
    logic [INDEX_BIT_LEN-1:0]  out_rule_q;
    logic                      out_overflow_q;
    logic [HOP_W-1:0]          hops_q;
    logic [INDEX_BIT_LEN-1:0]  cur_index_q;
    logic [PACKET_BIT_LEN-1:0] tuple_q;

    logic                      accept;
    logic                      release_result;

    assign accept         = bus.in_valid && in_ready_q;
    assign release_result = (state_q == DONE) && bus.out_ready;

    // Walk control; in_ready/out_valid are set on the transitions into IDLE/DONE
    // so that both remain plain register outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            out_match_q    <= 1'b0;
            out_rule_q     <= '0;
            out_overflow_q <= 1'b0;
            hops_q         <= '0;
            cur_index_q    <= '0;
            tuple_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cur_index_q    <= bus.in_head;
                        tuple_q        <= bus.in_tuple;
                        hops_q         <= '0;
                        out_overflow_q <= 1'b0;
                        in_ready_q     <= 1'b0;
                        state_q        <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    // Index is on the table bus this cycle; count the entry.
                    if (hops_q != HOP_SAT) begin
                        hops_q <= hops_q + HOP_W'(1);
                    end
                    state_q <= RESULT;
                end

                RESULT: begin
                    if (bus.tbl_match) begin
                        out_match_q <= 1'b1;
                        out_rule_q  <= bus.tbl_ruleID;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (bus.tbl_next_index == NULL_INDEX) begin
                        out_match_q <= 1'b0;
                        out_rule_q  <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (hops_q == HOP_LIMIT) begin
                        out_match_q    <= 1'b0;
                        out_rule_q     <= '0;
                        out_overflow_q <= 1'b1;
                        out_valid_q    <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        cur_index_q <= bus.tbl_next_index;
                        state_q     <= LOOKUP;
                    end
                end

                DONE: begin
                    // Result held stable until the consumer takes it.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.tbl_search_index = cur_index_q;
    assign bus.tbl_tuple        = tuple_q;
    assign bus.out_valid        = out_valid_q;
    assign bus.out_match        = out_match_q;
    assign bus.out_ruleID       = out_rule_q;
    assign bus.out_hops         = hops_q;
    assign bus.out_overflow     = out_overflow_q;

`ifdef G3_WALK_STATS_EN
    logic [31:0] stat_pkts_q;
    logic [31:0] stat_matches_q;
    logic [31:0] stat_overflows_q;

    // Counted once per delivered result; all counters wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkts_q      <= '0;
            stat_matches_q   <= '0;
            stat_overflows_q <= '0;
        end else if (release_result) begin
            stat_pkts_q <= stat_pkts_q + 32'd1;
            if (out_match_q) begin
                stat_matches_q <= stat_matches_q + 32'd1;
            end
            if (out_overflow_q) begin
                stat_overflows_q <= stat_overflows_q + 32'd1;
            end
        end
    end

    assign bus.stat_pkts      = stat_pkts_q;
    assign bus.stat_matches   = stat_matches_q;
    assign bus.stat_overflows = stat_overflows_q;
`else
    logic unused_release;
    assign unused_release     = release_result;
    assign bus.stat_pkts      = '0;
    assign bus.stat_matches   = '0;
    assign bus.stat_overflows = '0;
`endif

endmodule

// File: tb/tb_g3_chain_walker.sv
// tb_g3_chain_walker: randomized + directed bench for g3_chain_walker with a
// behavioural table model, a chain-walk reference model and a scoreboard.
module tb_g3_chain_walker;
    localparam int unsigned IW   = 11;
    localparam int unsigned PW   = 104;
    localparam int unsigned MH   = 4;
    localparam int unsigned NENT = 1 << IW;
    localparam logic [IW-1:0] NULLI = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    g3_chain_walker_if #(.INDEX_BIT_LEN(IW), .PACKET_BIT_LEN(PW)) bus ();

    g3_chain_walker #(
        .INDEX_BIT_LEN (IW),
        .PACKET_BIT_LEN(PW),
        .NULL_INDEX    (NULLI),
        .MAX_HOPS      (MH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // table contents: an entry matches when its flag is set and its key equals
    // the low byte of the packet tuple
    bit          t_match [NENT];
    logic [7:0]  t_key   [NENT];
    logic [IW-1:0] t_rule [NENT];
    logic [IW-1:0] t_next [NENT];

    // registered table stage
    always @(posedge clk) begin
        bus.tbl_match      <= t_match[bus.tbl_search_index] &&
                              (bus.tbl_tuple[7:0] == t_key[bus.tbl_search_index]);
        bus.tbl_ruleID     <= t_rule[bus.tbl_search_index];
        bus.tbl_next_index <= t_next[bus.tbl_search_index];
    end

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    typedef struct {
        bit            m;
        logic [IW-1:0] rid;
        int            hops;
        bit            ovf;
        int            acc;
    } exp_t;

    exp_t sb[$];

    // Reference: follow the chain entry by entry from the head.
    function automatic void walk(input logic [IW-1:0] head, input logic [7:0] key, output exp_t e);
        logic [IW-1:0] idx;
        bit            fin;
        idx = head; fin = 0;
        e.m = 0; e.rid = '0; e.hops = 0; e.ovf = 0; e.acc = 0;
        for (int h = 1; h <= int'(MH) && !fin; h++) begin
            e.hops = h;
            if (t_match[idx] && t_key[idx] == key) begin
                e.m = 1; e.rid = t_rule[idx]; fin = 1;
            end else if (t_next[idx] == NULLI) begin
                fin = 1;
            end else if (h == int'(MH)) begin
                e.ovf = 1; fin = 1;
            end else begin
                idx = t_next[idx];
            end
        end
    endfunction

    function automatic logic [PW-1:0] mk_tuple(input logic [7:0] key);
        logic [PW-1:0] t;
        t = '0;
        for (int i = 0; i < 4; i++) t = {t[PW-33:0], 32'($urandom)};
        t[7:0] = key;
        return t;
    endfunction

    // cycle counter (posedges)
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // out_ready policy: 0 = always ready, 1 = random, 2 = stalled
    int mode = 0;
    always @(posedge clk) begin
        #1;
        case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    // monitor / scoreboard
    bit   seen = 0;
    exp_t cur;
    int   n_hs = 0, n_hs_m = 0, n_hs_o = 0;
    logic last_m, last_ovf;
    logic [IW-1:0] last_rid;
    int   last_hops, last_lat;

    always @(negedge clk) begin
        if (rst) begin
            seen = 0;
        end else if (bus.out_valid) begin
            if (!seen) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 64'(bus.out_valid), 64'(0));
                end else begin
                    cur  = sb.pop_front();
                    seen = 1;
                    last_lat = cyc + 1 - cur.acc;
                    chk("latency", 64'(last_lat), 64'(2 * cur.hops + 1));
                end
            end
            if (seen) begin
                chk("out_match",    64'(bus.out_match),    64'(cur.m));
                chk("out_hops",     64'(bus.out_hops),     64'(cur.hops));
                chk("out_overflow", 64'(bus.out_overflow), 64'(cur.ovf));
                if (!cur.ovf) chk("out_ruleID", 64'(bus.out_ruleID), 64'(cur.rid));
                chk("in_ready_busy", 64'(bus.in_ready), 64'(0));
                if (bus.out_ready) begin
                    last_m = bus.out_match; last_rid = bus.out_ruleID;
                    last_hops = int'(bus.out_hops); last_ovf = bus.out_overflow;
                    seen = 0;
                    n_hs++;
                    if (cur.m)   n_hs_m++;
                    if (cur.ovf) n_hs_o++;
                end
            end
        end
    end

    // Issue one request; junk in_valid is driven while the walker is busy.
    task automatic send(input logic [IW-1:0] head, input logic [PW-1:0] tup);
        int   w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 400) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_head  = IW'($urandom);
            bus.in_tuple = mk_tuple(8'($urandom));
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 64'(bus.in_ready), 64'(1));
            bus.in_valid = 1'b0;
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_head  = head;
        bus.in_tuple = tup;
        walk(head, tup[7:0], e);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_head  = IW'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || bus.out_valid) && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain_pending", 64'(sb.size()), 64'(0));
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < int'(NENT); i++) begin
            t_match[i] = 0; t_key[i] = '0; t_rule[i] = '0; t_next[i] = NULLI;
        end
    endtask

    task automatic chain_379();
        clear_tbl();
        t_next[3] = IW'(7); t_next[7] = IW'(9); t_next[9] = NULLI;
        t_match[9] = 1; t_key[9] = 8'h22; t_rule[9] = IW'('h101);
    endtask

    task automatic rand_tbl();
        for (int i = 0; i < 32; i++) begin
            t_match[i] = ($urandom_range(0, 3) == 0);
            t_key[i]   = 8'($urandom_range(0, 3));
            t_rule[i]  = IW'($urandom);
            t_next[i]  = ($urandom_range(0, 3) == 0) ? NULLI : IW'($urandom_range(0, 31));
        end
        t_match[NULLI] = 1'($urandom_range(0, 1));
        t_key[NULLI]   = 8'($urandom_range(0, 3));
        t_rule[NULLI]  = IW'($urandom);
        t_next[NULLI]  = NULLI;
    endtask

    initial begin
        longint unsigned e_p, e_m, e_o;
        int w;
        bus.in_valid = 1'b0; bus.in_head = '0; bus.in_tuple = '0; bus.out_ready = 1'b1;
        clear_tbl();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_match", 64'(bus.out_match), 64'(0));
        chk("rst_ruleID",    64'(bus.out_ruleID), 64'(0));
        chk("rst_hops",      64'(bus.out_hops),  64'(0));
        chk("rst_overflow",  64'(bus.out_overflow), 64'(0));
        chk("rst_index",     64'(bus.tbl_search_index), 64'(0));
        chk("rst_stat_pkts", 64'(bus.stat_pkts), 64'(0));

        // single-entry match
        t_match[5] = 1; t_key[5] = 8'h11; t_rule[5] = IW'('h2A); t_next[5] = IW'(6);
        send(IW'(5), mk_tuple(8'h11)); drain();
        chk("single_match",  64'(last_m), 64'(1));
        chk("single_rule",   64'(last_rid), 64'('h2A));
        chk("single_hops",   64'(last_hops), 64'(1));
        chk("single_lat",    64'(last_lat), 64'(3));

        // three-hop chain, last entry matches
        chain_379();
        send(IW'(3), mk_tuple(8'h22)); drain();
        chk("chain_match", 64'(last_m), 64'(1));
        chk("chain_rule",  64'(last_rid), 64'('h101));
        chk("chain_hops",  64'(last_hops), 64'(3));
        chk("chain_lat",   64'(last_lat), 64'(7));

        // chain ends at NULL without a match
        t_next[7] = NULLI;
        send(IW'(3), mk_tuple(8'h22)); drain();
        chk("null_match", 64'(last_m), 64'(0));
        chk("null_rule",  64'(last_rid), 64'(0));
        chk("null_ovf",   64'(last_ovf), 64'(0));
        chk("null_hops",  64'(last_hops), 64'(2));

        // cycle 1->2->1 exhausts the hop budget
        clear_tbl();
        t_next[1] = IW'(2); t_next[2] = IW'(1);
        send(IW'(1), mk_tuple(8'h00)); drain();
        chk("cyc_ovf",   64'(last_ovf), 64'(1));
        chk("cyc_hops",  64'(last_hops), 64'(MH));
        chk("cyc_match", 64'(last_m), 64'(0));

        // stalled consumer holds the result, then a fresh accept follows
        t_match[5] = 1; t_key[5] = 8'h11; t_rule[5] = IW'('h2A); t_next[5] = NULLI;
        mode = 2;
        send(IW'(5), mk_tuple(8'h11));
        w = 0;
        while (!bus.out_valid && w < 100) begin @(negedge clk); w++; end
        chk("stall_valid_seen", 64'(bus.out_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold_valid", 64'(bus.out_valid), 64'(1));
        end
        mode = 0;
        drain();
        send(IW'(5), mk_tuple(8'h11)); drain();
        chk("after_stall_rule", 64'(last_rid), 64'('h2A));

        // randomized chains against the reference walk
        clear_tbl();
        rand_tbl();
        mode = 1;
        for (int n = 0; n < 60; n++) begin
            logic [IW-1:0] hd;
            hd = ($urandom_range(0, 7) == 0) ? NULLI : IW'($urandom_range(0, 31));
            send(hd, mk_tuple(8'($urandom_range(0, 3))));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();
        mode = 0;
        @(negedge clk);
`ifdef G3_WALK_STATS_EN
        e_p = 64'(n_hs); e_m = 64'(n_hs_m); e_o = 64'(n_hs_o);
`else
        e_p = 0; e_m = 0; e_o = 0;
`endif
        chk("stat_pkts",      64'(bus.stat_pkts),      e_p);
        chk("stat_matches",   64'(bus.stat_matches),   e_m);
        chk("stat_overflows", 64'(bus.stat_overflows), e_o);

        // reset during RESULT of the second hop abandons the walk
        chain_379();
        send(IW'(3), mk_tuple(8'h22));
        @(posedge clk); @(posedge clk); @(posedge clk);
        #1;
        chk("pre_rst_hops", 64'(bus.out_hops), 64'(2));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        n_hs = 0; n_hs_m = 0; n_hs_o = 0;
        @(negedge clk);
        chk("midrst_in_ready",  64'(bus.in_ready),  64'(1));
        chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("midrst_stat_pkts", 64'(bus.stat_pkts), 64'(0));
        chk("midrst_stat_match", 64'(bus.stat_matches), 64'(0));
        send(IW'(3), mk_tuple(8'h22)); drain();
        chk("post_rst_rule", 64'(last_rid), 64'('h101));
        @(negedge clk);
`ifdef G3_WALK_STATS_EN
        e_p = 1;
`else
        e_p = 0;
`endif
        chk("post_rst_stat_pkts", 64'(bus.stat_pkts), e_p);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
